// File: rtl/neuron_sum_serializer.sv
// Serializes one parallel word of NB accumulated neuron sums into one beat per neuron,
// saturating each sum to OW signed bits and tagging it with {last, index}.
module neuron_sum_serializer #(
   parameter int NA = 4,
   parameter int NB = 4,
   parameter int WD = 2,
   parameter int OW = 3,
   localparam int AW = $clog2(NA) + WD,
   localparam int IW = (NB > 1) ? $clog2(NB) : 1
) (
   input  logic                 iCLK,
   input  logic                 iRST,
   input  logic                 iValid_AS,
   output logic                 oReady_AS,
   input  logic [NB*AW-1:0]     iData_AS,
   output logic                 oValid_BS,
   input  logic                 iReady_BS,
   output logic [IW+OW:0]       oData_BS
);

   // Handshakes: a transfer happens on any rising edge where valid && ready are both 1;
   // a source holds valid and data stable until that edge, the sink may toggle ready freely.

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_DRAIN = 1'b1
   } state_t;

   localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

   state_t              state_q, state_d;
   logic [NB*AW-1:0]    rbuf_q, rbuf_d;
   logic [IW-1:0]       rcnt_q, rcnt_d;

   logic                last;
   logic                ready_int;
   logic                in_hs;
   logic signed [AW-1:0] cur_val;
   logic [OW-1:0]       sat_val;

   assign last    = (rcnt_q == LAST_IDX);
   assign cur_val = rbuf_q[int'(rcnt_q)*AW +: AW];

   generate
      if (OW > AW) begin : g_sext
         always_comb sat_val = {{(OW-AW){cur_val[AW-1]}}, cur_val};
      end else if (OW == AW) begin : g_pass
         always_comb sat_val = cur_val;
      end else begin : g_clamp
         localparam logic signed [AW-1:0] MAXV = AW'((1 << (OW-1)) - 1);
         localparam logic signed [AW-1:0] MINV = AW'(-(1 << (OW-1)));
         always_comb begin
            if (cur_val > MAXV)      sat_val = MAXV[OW-1:0];
            else if (cur_val < MINV) sat_val = MINV[OW-1:0];
            else                     sat_val = cur_val[OW-1:0];
         end
      end
   endgenerate

   // Ready at the last beat depends combinationally on iReady_BS so words chain without a bubble.
   assign ready_int = (state_q == S_EMPTY) || (last && iReady_BS);
   assign oReady_AS = iRST && ready_int;
   assign in_hs     = iValid_AS && oReady_AS;
   assign oValid_BS = iRST && (state_q == S_DRAIN);
   assign oData_BS  = oValid_BS ? {last, rcnt_q, sat_val} : '0;

   always_comb begin
      state_d = state_q;
      rbuf_d  = rbuf_q;
      rcnt_d  = rcnt_q;
      case (state_q)
         S_EMPTY: begin
            if (in_hs) begin
               rbuf_d  = iData_AS;
               rcnt_d  = '0;
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (iReady_BS) begin
               if (!last) begin
                  rcnt_d = rcnt_q + IW'(1);
               end else if (in_hs) begin
                  rbuf_d = iData_AS;
                  rcnt_d = '0;
               end else begin
                  rcnt_d  = '0;
                  state_d = S_EMPTY;
               end
            end
         end
         default: state_d = S_EMPTY;
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (!iRST) begin
         state_q <= S_EMPTY;
         rbuf_q  <= '0;
         rcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         rbuf_q  <= rbuf_d;
         rcnt_q  <= rcnt_d;
      end
   end

endmodule

// File: doc/neuron_sum_serializer.md
# neuron_sum_serializer

Downstream stage of the neuron accumulator core. It accepts one parallel word of NB accumulated neuron sums per handshake. It saturates each sum to a narrower signed output width and emits the sums one neuron per beat on a valid/ready stream tagged with neuron index and a last flag. It feeds the per-neuron activation/readout logic, which processes one neuron at a time.

## Interface
- NA, 4: number of accumulated inputs per neuron. Sets the accumulator growth bits, AW = $clog2(NA)+WD.
- NB, 4: neurons per input word.
- WD, 2: weight width seen by the accumulator.
- OW, 3: signed output value width, OW >= 2.
- Derived: AW = $clog2(NA)+WD. IW = (NB>1) ? $clog2(NB) : 1.
- iCLK  in  1  clock; all logic on the rising edge.
- iRST  in  1  synchronous, active-low reset (0 = reset).
- iValid_AS  in  1  input word valid.
- oReady_AS  out  1  input word accepted when iValid_AS && oReady_AS.
- iData_AS  in  NB*AW  neuron sums. Neuron k is at [k*AW +: AW], two's complement.
- oValid_BS  out  1  output beat valid.
- iReady_BS  in  1  output beat consumed when oValid_BS && iReady_BS.
- oData_BS  out  1+IW+OW  {last, index, value}. last is the MSB; value occupies [OW-1:0].

## Operation
- States:
  - EMPTY: no word held.
  - DRAIN: word held in buffer rbuf; counter rcnt (IW bits) selects the current neuron.
- EMPTY:
  - oReady_AS = 1 and oValid_BS = 0.
  - On input handshake: rbuf <= iData_AS, rcnt <= 0, go to DRAIN.
- DRAIN:
  - oValid_BS = 1.
  - Output fields: value = sat(rbuf[rcnt]), index = rcnt, last = (rcnt == NB-1).
  - Output handshake with last = 0: rcnt <= rcnt+1, stay in DRAIN.
  - Output handshake with last = 1 and no input handshake in the same cycle: go to EMPTY, rcnt <= 0.
  - Output handshake with last = 1 and input handshake in the same cycle: reload rbuf, rcnt <= 0, stay in DRAIN. This gives back-to-back words with no bubble.
- oReady_AS = (state == EMPTY) || (state == DRAIN && last && iReady_BS). The path from iReady_BS to oReady_AS is combinational; this is intended.
- Saturation, sat(x), with x as a signed AW-bit value:
  - If OW >= AW: sign-extend x to OW bits.
  - Else: clamp x to [-2^(OW-1), 2^(OW-1)-1], then take the low OW bits.
- While oValid_BS = 1 and iReady_BS = 0, oData_BS is held stable.
- Input word contents are never modified before emission. rbuf changes only on an input handshake.
- NB = 1: every beat has last = 1 and index = 0.
- Reset:
  - While iRST = 0: oReady_AS = 0, oValid_BS = 0, oData_BS = 0.
  - At the next edge with iRST = 0: state = EMPTY, rcnt = 0, rbuf = 0.
  - Reset mid-DRAIN discards the remaining neurons. No beat is emitted after reset until a new word is accepted.

## Timing
- Input accepted at edge t: first beat is valid in the cycle after t, with zero added bubbles.
- Throughput: one word per NB cycles when iReady_BS is held 1. Input is continuously ready at the last beat.
- Word latency from acceptance to last-beat handshake: NB cycles minimum.
- No combinational path from iValid_AS or iData_AS to any output. oData_BS is derived from registers only.
- Output backpressure stalls rcnt indefinitely; no data is lost or duplicated.

## Test plan
- Reset behaviour: hold iRST = 0 for 3 cycles with iValid_AS = 1 -> oReady_AS = 0 and oValid_BS = 0 throughout. After release, oReady_AS = 1 in the first cycle.
- Saturation and order (NA=4, NB=4, WD=2, OW=3): input sums {n0=3, n1=-2, n2=7, n3=-8} with iReady_BS = 1 -> beats {0,00,011}, {0,01,110}, {0,10,011}, {1,11,100} on 4 consecutive cycles.
- Back-to-back: two words presented continuously -> 8 consecutive valid beats. oReady_AS pulses only on the beat with index 3. No gap between 3 and 0.
- Backpressure: drop iReady_BS for 5 cycles at index 1 -> oData_BS stays {0,01,110}. Input iData_AS changes are ignored and oReady_AS = 0. Emission resumes at index 1.
- Sign-extend case (OW=6, AW=4): sum 4'b1001 -> value 6'b111001. Sum 4'b0111 -> value 6'b000111.
- Reset mid-drain: assert iRST = 0 at index 2 -> oValid_BS = 0 the same cycle. After release, no stale beats appear. The next word starts at index 0.
